// File: rtl/npc_mem_arbiter.sv
// npc_mem_arbiter: round-robin arbiter sharing one memory port between IFU and LSU.
// One transaction in flight at a time; client responses are one-cycle pulses.
module npc_mem_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ifu_req_valid,
   output logic              ifu_req_ready,
   input  logic [ADDR_W-1:0] ifu_addr,
   output logic              ifu_resp_valid,
   output logic [DATA_W-1:0] ifu_rdata,
   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic              lsu_wen,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic [DATA_W-1:0] lsu_wdata,
   input  logic [7:0]        lsu_wmask,
   output logic              lsu_resp_valid,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [7:0]        mem_wmask,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned MASK_W = 8;
   localparam logic OWN_IFU = 1'b0;
   localparam logic OWN_LSU = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_last_grant, w_last_grant_nxt;
   logic                r_owner, w_owner_nxt;
   logic                r_mem_req_valid, w_mem_req_valid_nxt;
   logic                r_mem_wen, w_mem_wen_nxt;
   logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
   logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
   logic [MASK_W-1:0]   r_mem_wmask, w_mem_wmask_nxt;
   logic                r_ifu_resp_valid, w_ifu_resp_valid_nxt;
   logic                r_lsu_resp_valid, w_lsu_resp_valid_nxt;
   logic [DATA_W-1:0]   r_ifu_rdata, w_ifu_rdata_nxt;
   logic [DATA_W-1:0]   r_lsu_rdata, w_lsu_rdata_nxt;
   logic [DATA_W-1:0]   w_resp_data;
   logic                w_grant_ifu;
   logic                w_grant_lsu;

   // Round-robin grant in IDLE; a tie goes to the client not granted last. Held off during reset.
   always_comb begin
      w_grant_ifu = 1'b0;
      w_grant_lsu = 1'b0;
      if (r_state == S_IDLE && reset) begin
         w_grant_ifu = ifu_req_valid & (~lsu_req_valid | (r_last_grant == OWN_LSU));
         w_grant_lsu = lsu_req_valid & (~ifu_req_valid | (r_last_grant == OWN_IFU));
      end
   end

   assign ifu_req_ready = w_grant_ifu;
   assign lsu_req_ready = w_grant_lsu;

   // Next-state and registered-output logic for IDLE -> REQ -> WAIT -> IDLE.
   always_comb begin
      w_state_nxt          = r_state;
      w_last_grant_nxt     = r_last_grant;
      w_owner_nxt          = r_owner;
      w_mem_req_valid_nxt  = r_mem_req_valid;
      w_mem_wen_nxt        = r_mem_wen;
      w_mem_addr_nxt       = r_mem_addr;
      w_mem_wdata_nxt      = r_mem_wdata;
      w_mem_wmask_nxt      = r_mem_wmask;
      w_ifu_resp_valid_nxt = 1'b0;
      w_lsu_resp_valid_nxt = 1'b0;
      w_ifu_rdata_nxt      = r_ifu_rdata;
      w_lsu_rdata_nxt      = r_lsu_rdata;
      w_resp_data          = r_mem_wen ? DATA_W'(0) : mem_rdata;
      case (r_state)
         S_IDLE: begin
            if (w_grant_ifu) begin
               w_mem_addr_nxt      = ifu_addr;
               w_mem_wen_nxt       = 1'b0;
               w_mem_wdata_nxt     = DATA_W'(0);
               w_mem_wmask_nxt     = MASK_W'(0);
               w_owner_nxt         = OWN_IFU;
               w_last_grant_nxt    = OWN_IFU;
               w_mem_req_valid_nxt = 1'b1;
               w_state_nxt         = S_REQ;
            end else if (w_grant_lsu) begin
               w_mem_addr_nxt      = lsu_addr;
               w_mem_wen_nxt       = lsu_wen;
               w_mem_wdata_nxt     = lsu_wdata;
               w_mem_wmask_nxt     = lsu_wmask;
               w_owner_nxt         = OWN_LSU;
               w_last_grant_nxt    = OWN_LSU;
               w_mem_req_valid_nxt = 1'b1;
               w_state_nxt         = S_REQ;
            end
         end
         S_REQ: begin
            if (mem_req_ready) begin
               w_mem_req_valid_nxt = 1'b0;
               w_state_nxt         = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_resp_valid) begin
               if (r_owner == OWN_IFU) begin
                  w_ifu_rdata_nxt      = w_resp_data;
                  w_ifu_resp_valid_nxt = 1'b1;
               end else begin
                  w_lsu_rdata_nxt      = w_resp_data;
                  w_lsu_resp_valid_nxt = 1'b1;
               end
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt         = S_IDLE;
            w_mem_req_valid_nxt = 1'b0;
         end
      endcase
   end

   // State and output registers; reset drops any in-flight transaction.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state          <= S_IDLE;
         r_last_grant     <= OWN_LSU;
         r_owner          <= OWN_IFU;
         r_mem_req_valid  <= 1'b0;
         r_mem_wen        <= 1'b0;
         r_mem_addr       <= ADDR_W'(0);
         r_mem_wdata      <= DATA_W'(0);
         r_mem_wmask      <= MASK_W'(0);
         r_ifu_resp_valid <= 1'b0;
         r_lsu_resp_valid <= 1'b0;
         r_ifu_rdata      <= DATA_W'(0);
         r_lsu_rdata      <= DATA_W'(0);
      end else begin
         r_state          <= w_state_nxt;
         r_last_grant     <= w_last_grant_nxt;
         r_owner          <= w_owner_nxt;
         r_mem_req_valid  <= w_mem_req_valid_nxt;
         r_mem_wen        <= w_mem_wen_nxt;
         r_mem_addr       <= w_mem_addr_nxt;
         r_mem_wdata      <= w_mem_wdata_nxt;
         r_mem_wmask      <= w_mem_wmask_nxt;
         r_ifu_resp_valid <= w_ifu_resp_valid_nxt;
         r_lsu_resp_valid <= w_lsu_resp_valid_nxt;
         r_ifu_rdata      <= w_ifu_rdata_nxt;
         r_lsu_rdata      <= w_lsu_rdata_nxt;
      end
   end

   assign mem_req_valid  = r_mem_req_valid;
   assign mem_wen        = r_mem_wen;
   assign mem_addr       = r_mem_addr;
   assign mem_wdata      = r_mem_wdata;
   assign mem_wmask      = r_mem_wmask;
   assign ifu_resp_valid = r_ifu_resp_valid;
   assign lsu_resp_valid = r_lsu_resp_valid;
   assign ifu_rdata      = r_ifu_rdata;
   assign lsu_rdata      = r_lsu_rdata;

endmodule
